// File: rtl/muldiv_seq_if.sv
// Execute-stage handshake between the pipeline control and muldiv_seq.
// The pipeline side is master; the sequencer is slave.
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, flush, funct3, a, b,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, flush, funct3, a, b,
        output stall, busy, done, result
    );
endinterface

// File: rtl/muldiv_seq.sv
// RV32M iterative multiply/divide sequencer.
// Shift-add multiply or restoring divide on a shared 2*XLEN accumulator.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input logic         clk,
    input logic         rst,
    muldiv_seq_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opb;
    logic [XLEN-1:0]   r_result;
    logic [2:0]        r_op;
    logic              r_neg_a;
    logic              r_neg_b;

    logic              w_accept;
    logic              w_a_sgn;
    logic              w_b_sgn;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic [XLEN-1:0]   w_min;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_spec_res;
    logic [XLEN:0]     w_msum;
    logic [2*XLEN-1:0] w_mul_nxt;
    logic [XLEN:0]     w_rsh;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_div_nxt;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_res;

    assign w_accept = (r_state == S_IDLE) & bus.start & ~bus.flush;

    assign w_a_sgn = (bus.funct3 == 3'b001) | (bus.funct3 == 3'b010)
                   | (bus.funct3 == 3'b100) | (bus.funct3 == 3'b110);
    assign w_b_sgn = (bus.funct3 == 3'b001) | (bus.funct3 == 3'b100)
                   | (bus.funct3 == 3'b110);
    assign w_a_neg = w_a_sgn & bus.a[XLEN-1];
    assign w_b_neg = w_b_sgn & bus.b[XLEN-1];
    assign w_abs_a = w_a_neg ? -bus.a : bus.a;
    assign w_abs_b = w_b_neg ? -bus.b : bus.b;

    // Divide-by-zero and signed overflow bypass the iteration entirely
    assign w_min     = {1'b1, {(XLEN-1){1'b0}}};
    assign w_div0    = bus.funct3[2] & (bus.b == '0);
    assign w_ovf     = bus.funct3[2] & ~bus.funct3[0]
                     & (bus.a == w_min) & (bus.b == '1);
    assign w_special = w_div0 | w_ovf;

    always_comb begin
        w_spec_res = '0;
        unique case (1'b1)
            w_div0:  w_spec_res = bus.funct3[1] ? bus.a : '1;
            default: w_spec_res = bus.funct3[1] ? '0 : bus.a;
        endcase
    end

    assign w_msum    = {1'b0, r_acc[2*XLEN-1:XLEN]}
                     + {1'b0, (r_acc[0] ? r_opb : '0)};
    assign w_mul_nxt = {w_msum, r_acc[XLEN-1:1]};

    // Remainder in the high half, quotient shifts into the low half
    assign w_rsh     = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_diff    = w_rsh - {1'b0, r_opb};
    assign w_div_nxt = {(w_diff[XLEN] ? w_rsh[XLEN-1:0] : w_diff[XLEN-1:0]),
                        r_acc[XLEN-2:0], ~w_diff[XLEN]};

    assign w_prod = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
    assign w_quo  = (r_neg_a ^ r_neg_b) ? -r_acc[XLEN-1:0]
                                        : r_acc[XLEN-1:0];
    assign w_rem  = r_neg_a ? -r_acc[2*XLEN-1:XLEN]
                            : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_fix_res = '0;
        unique case (1'b1)
            r_op[2] & r_op[1]:    w_fix_res = w_rem;
            r_op[2] & ~r_op[1]:   w_fix_res = w_quo;
            r_op == 3'b000:       w_fix_res = w_prod[XLEN-1:0];
            default:              w_fix_res = w_prod[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_next = w_special ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == CW'(XLEN-1)) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (bus.flush) w_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_op     <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_op    <= bus.funct3;
            r_neg_a <= w_a_neg;
            r_neg_b <= w_b_neg;
            r_acc   <= {{XLEN{1'b0}}, w_abs_a};
            r_opb   <= w_abs_b;
            if (w_special) r_result <= w_spec_res;
        end else if (r_state == S_CALC && !bus.flush) begin
            r_acc <= r_op[2] ? w_div_nxt : w_mul_nxt;
            r_cnt <= r_cnt + 1'b1;
        end else if (r_state == S_FIX && !bus.flush) begin
            r_result <= w_fix_res;
        end
    end

    assign bus.stall  = ~rst & (w_accept | (r_state == S_CALC)
                              | (r_state == S_FIX));
    assign bus.busy   = (r_state != S_IDLE);
    assign bus.done   = (r_state == S_DONE);
    assign bus.result = r_result;
endmodule

// File: tb/tb_muldiv_seq.sv
// Randomised scoreboard bench for muldiv_seq.
// Expected results come from plain 64-bit arithmetic.
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_seq_if #(.XLEN(32)) bus ();
    muldiv_seq #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] res;
        int          at;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_model(logic [2:0] f,
                                              logic [31:0] a,
                                              logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sbv = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        longint p;
        case (f)
            3'd0: p = sa * sbv;
            3'd1: p = (sa * sbv) >>> 32;
            3'd2: p = (sa * ub) >>> 32;
            3'd3: p = (ua * ub) >> 32;
            3'd4: p = (b == 0) ? -1 : sa / sbv;
            3'd5: p = (b == 0) ? -1 : ua / ub;
            3'd6: p = (b == 0) ? sa : sa % sbv;
            default: p = (b == 0) ? ua : ua % ub;
        endcase
        return p[31:0];
    endfunction

    function automatic int lat(logic [2:0] f, logic [31:0] a,
                               logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1;
        return 34;
    endfunction

    always @(negedge clk) begin
        if (bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)",
                         cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", bus.result, e.res);
                chk("done_cycle", cyc, e.at);
            end
        end
    end

    task automatic drive(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.a      = a;
        bus.b      = b;
    endtask

    task automatic expect_op(logic [31:0] res, int l);
        exp_t e;
        e.res = res;
        e.at  = cyc + l;
        sb.push_back(e);
        last_res = res;
    endtask

    task automatic wait_done();
        logic stall_ok = 1'b1;
        logic seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (!bus.stall) stall_ok = 1'b0;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 60");
        end else begin
            chk("stall_in_done", {31'b0, bus.stall}, 32'd0);
        end
        chk("stall_held", {31'b0, stall_ok}, 32'd1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_after", {31'b0, bus.busy}, 32'd0);
    endtask

    task automatic run_op(logic [2:0] f, logic [31:0] a, logic [31:0] b,
                          logic [31:0] res);
        drive(f, a, b);
        expect_op(res, lat(f, a, b));
        #1;
        chk("stall_accept", {31'b0, bus.stall}, 32'd1);
        wait_done();
    endtask

    logic [2:0]  d_f[12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6,
                             3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] d_a[12] = '{32'd7, '1, '1, '1, 32'hFFFF_FFF9,
                             32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5,
                             32'h1234, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b[12] = '{32'hFFFF_FFFD, '1, '1, '1, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, '1, '1};
    logic [31:0] d_r[12] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, '1,
                             32'hFFFF_FFFD, '1, 32'd14, 32'd2, '1,
                             32'h1234, 32'h8000_0000, 32'h0};

    initial begin
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;

        bus.start  = 1'b1;
        bus.flush  = 1'b0;
        bus.funct3 = '0;
        bus.a      = '0;
        bus.b      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", {31'b0, bus.stall}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) run_op(d_f[i], d_a[i], d_b[i], d_r[i]);

        // Flush mid-divide: no done, result untouched
        drive(3'd4, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush_busy", {31'b0, bus.busy}, 32'd0);
        chk("flush_result", bus.result, last_res);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_hold", bus.result, last_res);
        run_op(3'd4, 32'd1000, 32'd3, 32'd333);

        bus.start = 1'b1;
        bus.flush = 1'b1;
        #1;
        chk("flush_start_stall", {31'b0, bus.stall}, 32'd0);
        @(posedge clk);
        #1;
        chk("flush_start_busy", {31'b0, bus.busy}, 32'd0);
        bus.start = 1'b0;
        bus.flush = 1'b0;

        // Async reset mid-multiply with start held through it
        drive(3'd0, 32'd123, 32'd456);
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'b0, bus.busy}, 32'd0);
        chk("arst_done", {31'b0, bus.done}, 32'd0);
        chk("arst_stall", {31'b0, bus.stall}, 32'd0);
        chk("arst_result", bus.result, 32'd0);
        last_res = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_op(32'd56088, 34);
        wait_done();

        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = '1; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'h8000_0000;
                default: ;
            endcase
            run_op(f, a, b, ref_model(f, a, b));
        end

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
